vp_joykey_event_queue: RTL and testbench
========================================

// Module: vp_joykey_event_queue
// PURPOSE
//   Converts N_PADS gamepads' numeric-key bitmaps into an ordered queue of press/release events for the keyboard matrix emulation (vp_keymap feed).
//   Pads are OR-merged per key and every net state change is tracked, so a press always has a matching release (no stuck keys, no lost events).
//   Consumer pulls events with a valid/ack handshake. A programmable gap between events gives the keymap time to latch each one.
// PARAMETERS
//   N_PADS       2   number of gamepads merged
//   N_KEYS       10  keys per pad (index 0 = "1" ... 9 = "0")
//   FIFO_DEPTH   8   event queue depth, power of 2, >= 2
//   GAP_CYCLES   0   idle clk_sys cycles forced after each pop before next evt_valid
//   Derived: KW = $clog2(N_KEYS), AW = $clog2(FIFO_DEPTH)
// PORTS
//   clk_sys      in   1              system clock
//   reset        in   1              asynchronous, active-high
//   joy_keys_i   in   N_PADS*N_KEYS  pad p key k at bit p*N_KEYS+k, 1 = pressed
//   flush_i      in   1              sync clear of queue and tracked state
//   evt_valid_o  out  1              head event available
//   evt_key_o    out  KW             key index of head event
//   evt_rel_o    out  1              1 = release, 0 = press
//   evt_ack_i    in   1              pop head; ignored when evt_valid_o = 0
//   level_o      out  AW+1           queued event count, 0..FIFO_DEPTH
//   pending_o    out  1              a merged key differs from tracked state, not yet queued
// BEHAVIOUR
//   Reset (async): in_q, keys_q, FIFO pointers, level and gap counter = 0.
//     All outputs = 0.
//   Input stage: in_q <= joy_keys_i each clk. merged[k] = OR over p of in_q[p*N_KEYS+k].
//   Change vector: delta = merged ^ keys_q. pending_o = |delta (combinational).
//   Scanner: each cycle select the lowest k with delta[k]=1.
//     If the FIFO is not full, push {k, rel = ~merged[k]} and set keys_q[k] <= merged[k].
//     At most one push per cycle.
//     When full, no push occurs and keys_q holds. The change stays pending and is pushed later.
//     A press/release that reverts before its push produces no event (net-change semantics).
//   Full check uses the registered level only. A pop in the same cycle does NOT free a slot for a push in that cycle.
//   Pop: on evt_ack_i & evt_valid_o, advance the read pointer and load gap_cnt <= GAP_CYCLES.
//   Simultaneous push and pop (not full, not empty): level unchanged, both pointers advance.
//   Pointers are AW bits and wrap modulo FIFO_DEPTH. level_o is AW+1 bits, range 0..FIFO_DEPTH.
//   gap_cnt decrements by 1 each cycle while nonzero.
//   evt_valid_o = (level != 0) & (gap_cnt == 0). evt_key_o and evt_rel_o are the head entry, stable while valid.
//   Latency: joy_keys_i change sampled at edge t -> pushed at edge t+1 -> evt_valid_o high after t+1 (queue empty, gap 0).
//   flush_i (sync, highest priority over push/pop):
//     Pointers, level, gap_cnt and keys_q are cleared.
//     Keys still held afterwards re-emit press events starting the next cycle.
//   Reset asserted mid-operation: all state cleared immediately. No release events are emitted for keys that were held.
//   evt_ack_i without evt_valid_o: no effect.
// TESTING
//   1 Pad0 key 3 press at edge t -> evt_valid_o=1 after t+1, key=3, rel=0; ack -> valid=0, level=0.
//     Then release -> event key=3, rel=1.
//   2 Pad0 and pad1 both hold key 5 -> one press event only. Pad0 releases -> no event.
//     Pad1 releases -> exactly one event key=5, rel=1.
//   3 Keys 9, 2, 0 pressed in the same cycle, no ack -> level 1,2,3 on consecutive cycles.
//     Pops return keys 0, 2, 9 in that order, all rel=0.
//   4 FIFO_DEPTH=4, no ack, press keys 0..5 together -> level=4, pending_o=1.
//     After 2 acks, keys 4 and 5 are enqueued. Total 6 press events, no loss, no duplicates.
//   5 GAP_CYCLES=3, 3 events queued, ack held high -> evt_valid_o low for exactly 3 cycles after each pop.
//     3 pops occur over 12 cycles.
//   6 Key 7 held, 2 events queued, flush_i pulse -> level=0 next cycle.
//     One press event key=7 is re-emitted. Also assert reset mid-queue -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/vp_joykey_event_queue.sv
// Merges N_PADS numeric-key bitmaps and queues net press/release changes as ordered events
// for the keymap, drained through a valid/ack handshake with an optional post-pop gap.
module vp_joykey_event_queue #(
    parameter int unsigned N_PADS     = 2,
    parameter int unsigned N_KEYS     = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAP_CYCLES = 0,
    localparam int unsigned KW = $clog2(N_KEYS),
    localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [N_PADS*N_KEYS-1:0] joy_keys_i,
    input  logic                     flush_i,
    output logic                     evt_valid_o,
    output logic [KW-1:0]            evt_key_o,
    output logic                     evt_rel_o,
    input  logic                     evt_ack_i,
    output logic [AW:0]              level_o,
    output logic                     pending_o
);

    localparam int unsigned GW = $clog2(GAP_CYCLES + 2);

    typedef struct packed {
        logic [KW-1:0] key;
        logic          rel;
    } evt_t;

    logic [N_PADS*N_KEYS-1:0] in_q;
    logic [N_KEYS-1:0]        keys_q, keys_d;
    logic [N_KEYS-1:0]        merged, delta;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]              level_q, level_d;
    logic [GW-1:0]            gap_q, gap_d;
    evt_t                     mem_q [FIFO_DEPTH];
    evt_t                     mem_d [FIFO_DEPTH];
    evt_t                     head;
    logic [KW-1:0]            scan_key;
    logic                     scan_hit;
    logic                     full, empty, push, pop;

    always_comb begin
        merged = '0;
        for (int unsigned p = 0; p < N_PADS; p++) begin
            merged = merged | in_q[p*N_KEYS +: N_KEYS];
        end
    end

    assign delta = merged ^ keys_q;

    // Descending scan so the lowest changed key wins.
    always_comb begin
        scan_hit = 1'b0;
        scan_key = '0;
        for (int k = int'(N_KEYS) - 1; k >= 0; k--) begin
            if (delta[k]) begin
                scan_hit = 1'b1;
                scan_key = KW'(k);
            end
        end
    end

    // Full is judged on the registered level, so a same-cycle pop never frees a slot.
    assign full  = (level_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign evt_valid_o = !empty && (gap_q == '0);
    assign push  = scan_hit && !full && !flush_i;
    assign pop   = evt_ack_i && evt_valid_o && !flush_i;

    always_comb begin
        keys_d   = keys_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        gap_d    = gap_q;
        mem_d    = mem_q;
        if (flush_i) begin
            keys_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            gap_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q]  = '{key: scan_key, rel: ~merged[scan_key]};
                keys_d[scan_key] = merged[scan_key];
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                gap_d    = GW'(GAP_CYCLES);
            end else if (gap_q != '0) begin
                gap_d = gap_q - 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            in_q     <= '0;
            keys_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            gap_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            in_q     <= joy_keys_i;
            keys_q   <= keys_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            gap_q    <= gap_d;
            mem_q    <= mem_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign evt_key_o = head.key;
    assign evt_rel_o = head.rel;
    assign level_o   = level_q;
    assign pending_o = |delta;

endmodule

// File: tb/tb_vp_joykey_event_queue.sv
// Randomised and directed bench: a queue-based reference model feeds a scoreboard that a
// negedge monitor drains whenever the DUT hands over an event.
`timescale 1ns/1ps
module tb_vp_joykey_event_queue;

    localparam int NP    = 2;
    localparam int NK    = 10;
    localparam int DEPTH = 4;
    localparam int GAP   = 3;
    localparam int KW    = $clog2(NK);
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [KW-1:0] key;
        logic          rel;
    } evt_t;

    logic              clk_sys = 1'b0;
    logic              reset = 1'b0;
    logic [NP*NK-1:0]  joy_keys = '0;
    logic              flush = 1'b0;
    logic              ack = 1'b0;
    logic              evt_valid_o;
    logic [KW-1:0]     evt_key_o;
    logic              evt_rel_o;
    logic [AW:0]       level_o;
    logic              pending_o;

    int errors = 0;
    int checks = 0;

    vp_joykey_event_queue #(
        .N_PADS    (NP),
        .N_KEYS    (NK),
        .FIFO_DEPTH(DEPTH),
        .GAP_CYCLES(GAP)
    ) u_dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .joy_keys_i (joy_keys),
        .flush_i    (flush),
        .evt_valid_o(evt_valid_o),
        .evt_key_o  (evt_key_o),
        .evt_rel_o  (evt_rel_o),
        .evt_ack_i  (ack),
        .level_o    (level_o),
        .pending_o  (pending_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [NK-1:0] merge(input logic [NP*NK-1:0] v);
        logic [NK-1:0] r = '0;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < NK; k++)
                if (v[p*NK+k]) r[k] = 1'b1;
        return r;
    endfunction

    // Reference: model tracks the sampled pads, what the consumer believes is held, and the queue.
    evt_t          m_fifo[$];
    evt_t          exp_q[$];
    logic [NP*NK-1:0] m_in = '0;
    logic [NK-1:0] m_keys = '0;
    int            m_gap = 0;

    initial forever begin
        logic [NK-1:0] mg, d;
        bit            popv, done;
        evt_t          e;
        @(posedge clk_sys or posedge reset);
        if (reset) begin
            m_fifo.delete();
            exp_q.delete();
            m_in = '0;
            m_keys = '0;
            m_gap = 0;
        end else begin
            mg = merge(m_in);
            d = mg ^ m_keys;
            popv = ack && (m_fifo.size() > 0) && (m_gap == 0);
            if (flush) begin
                m_fifo.delete();
                exp_q.delete();
                m_keys = '0;
                m_gap = 0;
            end else begin
                if (d != '0 && m_fifo.size() < DEPTH) begin
                    done = 0;
                    for (int k = 0; k < NK; k++) begin
                        if (d[k] && !done) begin
                            done = 1;
                            e.key = KW'(k);
                            e.rel = !mg[k];
                            m_fifo.push_back(e);
                            exp_q.push_back(e);
                            m_keys[k] = mg[k];
                        end
                    end
                end
                if (popv) begin
                    void'(m_fifo.pop_front());
                    m_gap = GAP;
                end else if (m_gap > 0) begin
                    m_gap--;
                end
            end
            m_in = joy_keys;
        end
    end

    // Monitor: status each cycle, event contents whenever the DUT is about to pop.
    initial forever begin
        evt_t e;
        @(negedge clk_sys);
        if (!reset) begin
            check("level", 32'(level_o), 32'(m_fifo.size()));
            check("valid", 32'(evt_valid_o), 32'(m_fifo.size() > 0 && m_gap == 0));
            check("pending", 32'(pending_o), 32'(|(merge(m_in) ^ m_keys)));
            if (evt_valid_o && ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got key %0d, expected no event", evt_key_o);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_key", 32'(evt_key_o), 32'(e.key));
                    check("sb_rel", 32'(evt_rel_o), 32'(e.rel));
                end
            end
        end
    end

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk_sys);
        while (!evt_valid_o && n < 64) begin
            @(negedge clk_sys);
            n++;
        end
        if (!evt_valid_o) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: valid=0 after 64 cycles, expected 1", tag);
        end
    endtask

    task automatic pop_one(input int key, input bit rel, input string tag);
        wait_valid(tag);
        check({tag, "_key"}, 32'(evt_key_o), 32'(key));
        check({tag, "_rel"}, 32'(evt_rel_o), 32'(rel));
        @(posedge clk_sys); #1 ack = 1'b1;
        @(posedge clk_sys); #1 ack = 1'b0;
    endtask

    task automatic drive_keys(input logic [NP*NK-1:0] v);
        @(posedge clk_sys); #1 joy_keys = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int pops;
        #1 reset = 1'b1;
        #1;
        check("rst_valid", 32'(evt_valid_o), 0);
        check("rst_level", 32'(level_o), 0);
        check("rst_pending", 32'(pending_o), 0);
        check("rst_key", 32'(evt_key_o), 0);
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;

        // 1: single press latency, ack, then release
        drive_keys(20'h00008);
        @(negedge clk_sys); check("t1_v0", 32'(evt_valid_o), 0);
        @(negedge clk_sys); check("t1_v1", 32'(evt_valid_o), 0);
        @(negedge clk_sys); check("t1_v2", 32'(evt_valid_o), 1);
        check("t1_key", 32'(evt_key_o), 3);
        check("t1_rel", 32'(evt_rel_o), 0);
        @(posedge clk_sys); #1 ack = 1'b1;
        @(posedge clk_sys); #1 ack = 1'b0;
        @(negedge clk_sys);
        check("t1_pop_valid", 32'(evt_valid_o), 0);
        check("t1_pop_level", 32'(level_o), 0);
        drive_keys(20'h00000);
        pop_one(3, 1, "t1_rel");

        // 2: both pads on key 5 merge into one press/release pair
        drive_keys(20'h08020);
        pop_one(5, 0, "t2_press");
        drive_keys(20'h08000);
        repeat (6) @(negedge clk_sys);
        check("t2_no_evt_level", 32'(level_o), 0);
        check("t2_no_evt_pend", 32'(pending_o), 0);
        drive_keys(20'h00000);
        pop_one(5, 1, "t2_rel");

        // 3: simultaneous presses queue lowest key first, one per cycle
        repeat (5) @(negedge clk_sys);
        drive_keys(20'h00205);
        @(negedge clk_sys); check("t3_lvl_a", 32'(level_o), 0);
        @(negedge clk_sys); check("t3_lvl_b", 32'(level_o), 0);
        @(negedge clk_sys); check("t3_lvl_1", 32'(level_o), 1);
        @(negedge clk_sys); check("t3_lvl_2", 32'(level_o), 2);
        @(negedge clk_sys); check("t3_lvl_3", 32'(level_o), 3);
        pop_one(0, 0, "t3_p0");
        pop_one(2, 0, "t3_p2");
        pop_one(9, 0, "t3_p9");
        drive_keys(20'h00000);
        pop_one(0, 1, "t3_r0");
        pop_one(2, 1, "t3_r2");
        pop_one(9, 1, "t3_r9");

        // 4: overflow holds changes pending until slots free up
        drive_keys(20'h0003F);
        repeat (8) @(negedge clk_sys);
        check("t4_full", 32'(level_o), DEPTH);
        check("t4_pending", 32'(pending_o), 1);
        for (int k = 0; k < 6; k++) pop_one(k, 0, "t4_press");
        drive_keys(20'h00000);
        for (int k = 0; k < 6; k++) pop_one(k, 1, "t4_rel");

        // 5: ack held high, gap spaces pops four cycles apart
        drive_keys(20'h00052);
        repeat (8) @(negedge clk_sys);
        check("t5_level", 32'(level_o), 3);
        pops = 0;
        @(posedge clk_sys); #1 ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_sys);
            check("t5_gap_valid", 32'(evt_valid_o), 32'(i % 4 == 0));
            if (evt_valid_o) pops++;
        end
        @(posedge clk_sys); #1 ack = 1'b0;
        check("t5_pops", 32'(pops), 3);
        @(negedge clk_sys); check("t5_empty", 32'(level_o), 0);
        drive_keys(20'h00000);
        pop_one(1, 1, "t5_r1");
        pop_one(4, 1, "t5_r4");
        pop_one(6, 1, "t5_r6");

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            @(posedge clk_sys); #1;
            if ($urandom_range(0, 2) == 0) joy_keys[$urandom_range(0, NP*NK-1)] ^= 1'b1;
            ack = ($urandom_range(0, 1) == 1);
            flush = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk_sys); #1 ack = 1'b0; joy_keys = '0; flush = 1'b1;
        @(posedge clk_sys); #1 flush = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("rnd_idle_level", 32'(level_o), 0);

        // 6: flush drops queued events and re-emits held key
        drive_keys(20'h00080);
        pop_one(7, 0, "t6_hold");
        drive_keys(20'h00084);
        repeat (4) @(negedge clk_sys);
        drive_keys(20'h00080);
        repeat (4) @(negedge clk_sys);
        check("t6_queued", 32'(level_o), 2);
        @(posedge clk_sys); #1 flush = 1'b1;
        @(posedge clk_sys); #1 flush = 1'b0;
        @(negedge clk_sys);
        check("t6_flush_level", 32'(level_o), 0);
        check("t6_flush_valid", 32'(evt_valid_o), 0);
        @(negedge clk_sys); check("t6_reemit_level", 32'(level_o), 1);
        pop_one(7, 0, "t6_reemit");
        repeat (6) @(negedge clk_sys);
        check("t6_single", 32'(level_o), 0);

        // Reset mid-queue clears everything without release events
        drive_keys(20'h04080);
        repeat (4) @(negedge clk_sys);
        check("t6_pre_rst", 32'(level_o), 1);
        @(posedge clk_sys); #3 reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(evt_valid_o), 0);
        check("t6_rst_level", 32'(level_o), 0);
        check("t6_rst_pending", 32'(pending_o), 0);
        check("t6_rst_key", 32'(evt_key_o), 0);
        check("t6_rst_rel", 32'(evt_rel_o), 0);
        joy_keys = '0;
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk_sys);
        check("t6_post_rst_level", 32'(level_o), 0);
        check("t6_post_rst_pend", 32'(pending_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
